// File: rtl/ipv4_daddr_extract.sv
// ipv4_daddr_extract
//   Passive tap on a 256-bit AXI4-Stream packet bus. It pulls the IPv4
//   destination address and header sanity flags out of each packet. It emits
//   exactly one single-cycle result per packet, so a downstream per-packet
//   FIFO stays aligned with the stream.
//
// Ports
//   clk                 core clock
//   reset               synchronous, active-high reset
//   s_axis_tdata        packet data, byte k at tdata[255-8k -: 8]
//   s_axis_tstrb        byte enables (not interpreted)
//   s_axis_tuser        sideband (not interpreted)
//   s_axis_tvalid       beat valid
//   s_axis_tready       consumer ready (observed only)
//   s_axis_tlast        last beat of packet
//   o_ipv4_daddr        frame bytes 30..33, big-endian
//   o_ipv4_daddr_valid  one-cycle pulse per packet
//   o_is_ipv4           ethertype 0x0800, version 4, IHL >= 5
//   o_ipv4_hdr_ok       o_is_ipv4, IHL == 5 and header checksum verifies
module ipv4_daddr_extract #(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    output logic [31:0]                       o_ipv4_daddr,
    output logic                              o_ipv4_daddr_valid,
    output logic                              o_is_ipv4,
    output logic                              o_ipv4_hdr_ok
);

    typedef enum logic [1:0] {StSop, StHdr2, StPayload} state_e;

    state_e       state_q, state_d;
    logic         accept;

    // Holding registers captured from beat 0
    logic [15:0]  ethertype_q;
    logic [7:0]   ver_ihl_q;
    logic [15:0]  daddr_hi_q;
    logic [19:0]  csum_q;

    // Output registers and their next values
    logic [31:0]  daddr_q, daddr_d;
    logic         valid_q, valid_d;
    logic         is_ipv4_q, is_ipv4_d;
    logic         hdr_ok_q, hdr_ok_d;

    logic [19:0]  sop_sum;
    logic [19:0]  hdr_sum, fold1, fold2;
    logic         csum_good, is_ipv4_calc, hdr_ok_calc;

    // Bytes k and k+1 are adjacent, so a big-endian word is one 16-bit slice
    function automatic logic [15:0] get_word(input logic [255:0] d, input int k);
        return d[255-8*k -: 16];
    endfunction

    assign accept = s_axis_tvalid && s_axis_tready;

    // Partial header sum over frame bytes 14..31 (nine words)
    always_comb begin
        sop_sum = '0;
        for (int i = 0; i < 9; i++) begin
            sop_sum = sop_sum + {4'h0, get_word(s_axis_tdata, 14 + 2*i)};
        end
    end

    // Beat 1 starts at frame byte 32, so the last header word is its word 0
    always_comb begin
        hdr_sum      = csum_q + {4'h0, get_word(s_axis_tdata, 0)};
        fold1        = {4'h0, hdr_sum[15:0]} + {16'h0, hdr_sum[19:16]};
        fold2        = {4'h0, fold1[15:0]} + {16'h0, fold1[19:16]};
        csum_good    = (fold2 == 20'h0ffff);
        is_ipv4_calc = (ethertype_q == 16'h0800) && (ver_ihl_q[7:4] == 4'd4) &&
                       (ver_ihl_q[3:0] >= 4'd5);
        hdr_ok_calc  = is_ipv4_calc && (ver_ihl_q[3:0] == 4'd5) && csum_good;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StSop;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (accept) begin
            unique case (state_q)
                StSop:     state_d = s_axis_tlast ? StSop : StHdr2;
                StHdr2:    state_d = s_axis_tlast ? StSop : StPayload;
                StPayload: state_d = s_axis_tlast ? StSop : StPayload;
                default:   state_d = StSop;
            endcase
        end
    end

    // Output logic: data outputs hold until the next pulse
    always_comb begin
        valid_d   = 1'b0;
        daddr_d   = daddr_q;
        is_ipv4_d = is_ipv4_q;
        hdr_ok_d  = hdr_ok_q;
        if (accept) begin
            unique case (state_q)
                StSop: begin
                    // Runt: report zeros so the result FIFO still gets an entry
                    if (s_axis_tlast) begin
                        valid_d   = 1'b1;
                        daddr_d   = '0;
                        is_ipv4_d = 1'b0;
                        hdr_ok_d  = 1'b0;
                    end
                end
                StHdr2: begin
                    valid_d   = 1'b1;
                    daddr_d   = {daddr_hi_q, get_word(s_axis_tdata, 0)};
                    is_ipv4_d = is_ipv4_calc;
                    hdr_ok_d  = hdr_ok_calc;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ethertype_q <= '0;
            ver_ihl_q   <= '0;
            daddr_hi_q  <= '0;
            csum_q      <= '0;
        end else if (accept && (state_q == StSop)) begin
            ethertype_q <= get_word(s_axis_tdata, 12);
            ver_ihl_q   <= s_axis_tdata[255-8*14 -: 8];
            daddr_hi_q  <= get_word(s_axis_tdata, 30);
            csum_q      <= sop_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            daddr_q   <= '0;
            valid_q   <= 1'b0;
            is_ipv4_q <= 1'b0;
            hdr_ok_q  <= 1'b0;
        end else begin
            daddr_q   <= daddr_d;
            valid_q   <= valid_d;
            is_ipv4_q <= is_ipv4_d;
            hdr_ok_q  <= hdr_ok_d;
        end
    end

    assign o_ipv4_daddr       = daddr_q;
    assign o_ipv4_daddr_valid = valid_q;
    assign o_is_ipv4          = is_ipv4_q;
    assign o_ipv4_hdr_ok      = hdr_ok_q;

    // Most data bytes, strobes and sideband are deliberately not interpreted
    logic unused_inputs;
    assign unused_inputs = ^{s_axis_tdata, s_axis_tstrb, s_axis_tuser};

endmodule

// File: tb/tb_ipv4_daddr_extract.sv
module tb_ipv4_daddr_extract;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] tdata;
    logic [31:0]  tstrb;
    logic [127:0] tuser;
    logic         tvalid, tready, tlast;
    logic [31:0]  o_ipv4_daddr;
    logic         o_ipv4_daddr_valid, o_is_ipv4, o_ipv4_hdr_ok;

    always #5 clk = ~clk;

    ipv4_daddr_extract dut (
        .clk                (clk),
        .reset              (reset),
        .s_axis_tdata       (tdata),
        .s_axis_tstrb       (tstrb),
        .s_axis_tuser       (tuser),
        .s_axis_tvalid      (tvalid),
        .s_axis_tready      (tready),
        .s_axis_tlast       (tlast),
        .o_ipv4_daddr       (o_ipv4_daddr),
        .o_ipv4_daddr_valid (o_ipv4_daddr_valid),
        .o_is_ipv4          (o_is_ipv4),
        .o_ipv4_hdr_ok      (o_ipv4_hdr_ok)
    );

    typedef struct {
        int          cyc;
        logic [31:0] daddr;
        logic        is4;
        logic        ok;
    } pulse_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [7:0]  frm [0:127];
    pulse_t      pq[$];   // observed pulses
    pulse_t      eq[$];   // expected pulses

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (o_ipv4_daddr_valid === 1'b1) begin
            pulse_t p;
            p.cyc = cyc; p.daddr = o_ipv4_daddr; p.is4 = o_is_ipv4; p.ok = o_ipv4_hdr_ok;
            pq.push_back(p);
        end
    end

    // Build a frame with a correct IPv4 header checksum at bytes 24..25, then
    // XOR 'corrupt' into byte 25.
    task automatic make_frame(input logic [15:0] etype, input logic [7:0] vihl,
                              input logic [31:0] da, input logic [7:0] corrupt);
        int unsigned s;
        logic [15:0] cs;
        for (int i = 0; i < 128; i++) frm[i] = 8'($urandom);
        frm[12] = etype[15:8]; frm[13] = etype[7:0]; frm[14] = vihl;
        frm[30] = da[31:24]; frm[31] = da[23:16]; frm[32] = da[15:8]; frm[33] = da[7:0];
        frm[24] = 8'h00; frm[25] = 8'h00;
        s = 0;
        for (int k = 14; k < 34; k += 2) s = s + 32'({frm[k], frm[k+1]});
        while ((s >> 16) != 0) s = (s & 32'hffff) + (s >> 16);
        cs = ~s[15:0];
        frm[24] = cs[15:8];
        frm[25] = cs[7:0] ^ corrupt;
    endtask

    // Reference: what the packet in frm should report
    function automatic pulse_t model(input int nbeats);
        pulse_t      r;
        int unsigned s;
        logic [15:0] et;
        logic [3:0]  ver, ihl;
        r.cyc = 0; r.daddr = '0; r.is4 = 1'b0; r.ok = 1'b0;
        if (nbeats < 2) return r;
        et  = {frm[12], frm[13]};
        ver = frm[14][7:4];
        ihl = frm[14][3:0];
        s = 0;
        for (int k = 14; k < 34; k += 2) s = s + 32'({frm[k], frm[k+1]});
        while ((s >> 16) != 0) s = (s & 32'hffff) + (s >> 16);
        r.daddr = {frm[30], frm[31], frm[32], frm[33]};
        r.is4   = (et == 16'h0800) && (ver == 4'd4) && (ihl >= 4'd5);
        r.ok    = r.is4 && (ihl == 4'd5) && (s == 32'hffff);
        return r;
    endfunction

    task automatic load_beat(input int b);
        for (int j = 0; j < 32; j++) tdata[255-8*j -: 8] = frm[32*b + j];
        tstrb = 32'($urandom);
        tuser = {4{32'($urandom)}};
    endtask

    task automatic idle(input int n);
        tvalid = 1'b0; tlast = 1'b0;
        repeat (n) begin
            tready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        tready = 1'b1;
    endtask

    // Drive frm as nbeats beats; stall_b1 cycles of tready low before beat 1;
    // rnd inserts random tvalid/tready bubbles before every beat.
    task automatic send_pkt(input int nbeats, input int stall_b1, input bit rnd);
        pulse_t e;
        e = model(nbeats);
        for (int b = 0; b < nbeats; b++) begin
            load_beat(b);
            if (b == 1 && stall_b1 > 0) begin
                tvalid = 1'b1; tready = 1'b0; tlast = (nbeats == 2);
                repeat (stall_b1) begin @(posedge clk); #1; end
            end
            if (rnd) begin
                repeat ($urandom_range(0, 2)) begin
                    tvalid = 1'($urandom_range(0, 1));
                    tready = tvalid ? 1'b0 : 1'($urandom_range(0, 1));
                    tlast  = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
            tvalid = 1'b1; tready = 1'b1; tlast = (b == nbeats - 1);
            @(posedge clk); #1;
            if (b == ((nbeats == 1) ? 0 : 1)) begin
                e.cyc = cyc;
                eq.push_back(e);
            end
        end
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; tvalid = 1'b1; tready = 1'b1; tlast = 1'b1;
        tdata = {8{32'($urandom)}}; tstrb = '1; tuser = '0;
        repeat (3) begin @(posedge clk); #1; end
        tests++; if (o_ipv4_daddr !== 32'h0) begin fails++;
            $display("FAIL reset_daddr: got %h want 0", o_ipv4_daddr); end
        tests++; if (o_ipv4_daddr_valid !== 1'b0) begin fails++;
            $display("FAIL reset_valid: got %b want 0", o_ipv4_daddr_valid); end
        tests++; if (o_is_ipv4 !== 1'b0) begin fails++;
            $display("FAIL reset_is_ipv4: got %b want 0", o_is_ipv4); end
        tests++; if (o_ipv4_hdr_ok !== 1'b0) begin fails++;
            $display("FAIL reset_hdr_ok: got %b want 0", o_ipv4_hdr_ok); end
        tvalid = 1'b0; tlast = 1'b0; reset = 1'b0;
        idle(2);
        pq.delete(); eq.delete();
    endtask

    // Good and corrupted-checksum IPv4 frames, 3 beats each
    task automatic test_ipv4_csum();
        pulse_t p;
        logic [7:0] cor;
        for (int t = 0; t < 2; t++) begin
            cor = (t == 0) ? 8'h00 : 8'h01;
            make_frame(16'h0800, 8'h45, 32'h0a000101, cor);
            send_pkt(3, 0, 0);
            idle(4);
            tests++;
            if (pq.size() !== 1 || eq.size() !== 1) begin fails++;
                $display("FAIL csum%0d_count: got %0d pulses want 1", t, pq.size());
            end else begin
                p = pq.pop_front();
                tests++; if (p.daddr !== 32'h0a000101) begin fails++;
                    $display("FAIL csum%0d_daddr: got %h want 0a000101", t, p.daddr); end
                tests++; if (p.is4 !== 1'b1) begin fails++;
                    $display("FAIL csum%0d_is_ipv4: got %b want 1", t, p.is4); end
                tests++; if (p.ok !== (t == 0)) begin fails++;
                    $display("FAIL csum%0d_hdr_ok: got %b want %0d", t, p.ok, t == 0); end
                tests++; if (p.cyc !== eq[0].cyc) begin fails++;
                    $display("FAIL csum%0d_latency: pulse cyc %0d want %0d", t, p.cyc, eq[0].cyc); end
            end
            tests++; if (o_ipv4_daddr !== 32'h0a000101) begin fails++;
                $display("FAIL csum%0d_hold: got %h want 0a000101", t, o_ipv4_daddr); end
            pq.delete(); eq.delete();
        end
    endtask

    task automatic test_arp();
        pulse_t p;
        make_frame(16'h0806, 8'h45, 32'hdeadbeef, 8'h00);
        send_pkt(2, 0, 0);
        idle(3);
        tests++;
        if (pq.size() !== 1) begin fails++;
            $display("FAIL arp_count: got %0d pulses want 1", pq.size());
        end else begin
            p = pq.pop_front();
            tests++; if (p.daddr !== 32'hdeadbeef) begin fails++;
                $display("FAIL arp_daddr: got %h want deadbeef", p.daddr); end
            tests++; if (p.is4 !== 1'b0 || p.ok !== 1'b0) begin fails++;
                $display("FAIL arp_flags: got is=%b ok=%b want 0 0", p.is4, p.ok); end
        end
        pq.delete(); eq.delete();
    endtask

    task automatic test_runt();
        pulse_t p;
        make_frame(16'h0800, 8'h45, 32'h11223344, 8'h00);
        send_pkt(1, 0, 0);
        make_frame(16'h0800, 8'h45, 32'h0a0000fe, 8'h00);
        send_pkt(2, 0, 0);
        idle(3);
        tests++;
        if (pq.size() !== 2 || eq.size() !== 2) begin fails++;
            $display("FAIL runt_count: got %0d pulses want 2", pq.size());
        end else begin
            p = pq.pop_front();
            tests++; if (p.daddr !== 32'h0 || p.is4 !== 1'b0 || p.ok !== 1'b0) begin fails++;
                $display("FAIL runt_values: got %h %b %b want 0 0 0", p.daddr, p.is4, p.ok); end
            tests++; if (p.cyc !== eq[0].cyc) begin fails++;
                $display("FAIL runt_latency: pulse cyc %0d want %0d", p.cyc, eq[0].cyc); end
            p = pq.pop_front();
            tests++; if (p.daddr !== 32'h0a0000fe || p.is4 !== 1'b1 || p.ok !== 1'b1) begin
                fails++;
                $display("FAIL runt_next: got %h %b %b want 0a0000fe 1 1", p.daddr, p.is4, p.ok);
            end
        end
        pq.delete(); eq.delete();
    endtask

    task automatic test_stall();
        pulse_t p;
        make_frame(16'h0800, 8'h45, 32'h0a000101, 8'h00);
        send_pkt(2, 5, 0);
        idle(3);
        tests++;
        if (pq.size() !== 1 || eq.size() !== 1) begin fails++;
            $display("FAIL stall_count: got %0d pulses want 1", pq.size());
        end else begin
            p = pq.pop_front();
            tests++; if (p.cyc !== eq[0].cyc) begin fails++;
                $display("FAIL stall_latency: pulse cyc %0d want %0d", p.cyc, eq[0].cyc); end
            tests++; if (p.daddr !== 32'h0a000101 || p.is4 !== 1'b1 || p.ok !== 1'b1) begin
                fails++;
                $display("FAIL stall_values: got %h %b %b want 0a000101 1 1", p.daddr, p.is4, p.ok);
            end
        end
        pq.delete(); eq.delete();
    endtask

    task automatic test_back_to_back();
        pulse_t p;
        make_frame(16'h0800, 8'h45, 32'hc0a80001, 8'h00);
        send_pkt(2, 0, 0);
        make_frame(16'h0800, 8'h45, 32'hc0a80002, 8'h00);
        send_pkt(2, 0, 0);
        // Third packet: beat 0 accepted, reset lands on beat 1
        make_frame(16'h0800, 8'h45, 32'hc0a80003, 8'h00);
        load_beat(0); tvalid = 1'b1; tready = 1'b1; tlast = 1'b0;
        @(posedge clk); #1;
        load_beat(1); tlast = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        tests++; if (o_ipv4_daddr !== 32'h0 || o_is_ipv4 !== 1'b0 || o_ipv4_hdr_ok !== 1'b0)
            begin fails++;
            $display("FAIL b2b_reset_clear: got %h %b %b want 0 0 0",
                     o_ipv4_daddr, o_is_ipv4, o_ipv4_hdr_ok); end
        reset = 1'b0;
        idle(3);
        tests++;
        if (pq.size() !== 2 || eq.size() !== 2) begin fails++;
            $display("FAIL b2b_count: got %0d pulses want 2", pq.size());
        end else begin
            p = pq.pop_front();
            tests++; if (p.daddr !== 32'hc0a80001 || p.cyc !== eq[0].cyc) begin fails++;
                $display("FAIL b2b_first: got %h cyc %0d want c0a80001 cyc %0d",
                         p.daddr, p.cyc, eq[0].cyc); end
            p = pq.pop_front();
            tests++; if (p.daddr !== 32'hc0a80002 || p.cyc !== eq[1].cyc || p.ok !== 1'b1) begin
                fails++;
                $display("FAIL b2b_second: got %h cyc %0d ok %b want c0a80002 cyc %0d ok 1",
                         p.daddr, p.cyc, p.ok, eq[1].cyc); end
        end
        pq.delete(); eq.delete();
        // After reset the next beat is a fresh SOP
        make_frame(16'h0800, 8'h45, 32'hc0a80004, 8'h00);
        send_pkt(2, 0, 0);
        idle(3);
        tests++;
        if (pq.size() !== 1) begin fails++;
            $display("FAIL b2b_after_reset_count: got %0d pulses want 1", pq.size());
        end else begin
            p = pq.pop_front();
            tests++; if (p.daddr !== 32'hc0a80004 || p.ok !== 1'b1) begin fails++;
                $display("FAIL b2b_after_reset: got %h ok %b want c0a80004 ok 1", p.daddr, p.ok);
            end
        end
        pq.delete(); eq.delete();
    endtask

    task automatic test_random();
        pulse_t p, e;
        logic [15:0] et;
        logic [7:0]  vihl, cor;
        int          sel;
        for (int n = 0; n < 40; n++) begin
            sel  = $urandom_range(0, 9);
            et   = (sel < 7) ? 16'h0800 : (sel == 7) ? 16'h0806 : 16'($urandom);
            vihl = ($urandom_range(0, 3) != 0) ? 8'h45 : 8'($urandom);
            cor  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            make_frame(et, vihl, 32'($urandom), cor);
            send_pkt($urandom_range(1, 4), 0, 1);
        end
        idle(4);
        tests++;
        if (pq.size() !== eq.size()) begin fails++;
            $display("FAIL rand_count: got %0d pulses want %0d", pq.size(), eq.size());
        end
        while (pq.size() > 0 && eq.size() > 0) begin
            p = pq.pop_front();
            e = eq.pop_front();
            tests++;
            if (p.cyc !== e.cyc || p.daddr !== e.daddr || p.is4 !== e.is4 || p.ok !== e.ok) begin
                fails++;
                $display("FAIL rand_pulse: got cyc %0d %h %b %b want cyc %0d %h %b %b",
                         p.cyc, p.daddr, p.is4, p.ok, e.cyc, e.daddr, e.is4, e.ok);
            end
        end
        pq.delete(); eq.delete();
    endtask

    initial begin
        test_reset();
        test_ipv4_csum();
        test_arp();
        test_runt();
        test_stall();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
